// File: rtl/div_arbiter_pkg.sv
// Shared types and constants for the divider arbiter: controller state codes,
// divider handshake levels and the operand payload latched per operation.
package div_arbiter_pkg;

    localparam int unsigned DATA_W   = 32;
    localparam int unsigned RESULT_W = 64;

    // Divider handshake levels
    localparam logic DIV_START        = 1'b1;
    localparam logic DIV_STOP         = 1'b0;
    localparam logic DIV_RESULT_READY = 1'b1;

    // Controller state codes
    typedef enum logic [1:0] {
        DIV_CTRL_IDLE   = 2'b00,
        DIV_CTRL_BUSY   = 2'b01,
        DIV_CTRL_DONE   = 2'b10,
        DIV_CTRL_CANCEL = 2'b11
    } div_ctrl_state_e;

    // Operand payload held stable on the divider inputs for a whole operation
    typedef struct packed {
        logic              is_signed;
        logic [DATA_W-1:0] op1;
        logic [DATA_W-1:0] op2;
    } div_op_t;

    // (base + off) modulo n, for base < n and off < n
    function automatic int unsigned wrap_add(int unsigned base, int unsigned off,
                                             int unsigned n);
        int unsigned s;
        s = base + off;
        return (s >= n) ? (s - n) : s;
    endfunction

endpackage

// File: rtl/div_arbiter_rr_arbiter.sv
// Round-robin picker: first eligible (req & ~mask) slot at or after the pointer.
// Ports: clk, rst (async active-low), req_i/mask_i (NUM_REQ), advance_i (commit
// grant, pointer moves past the granted slot), gnt_c (one-hot), idx_c (granted
// slot), any_c (some slot eligible). Outputs are combinational.
module div_arbiter_rr_arbiter
    import div_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned ID_W    = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [NUM_REQ-1:0] mask_i,
    input  logic               advance_i,
    output logic [NUM_REQ-1:0] gnt_c,
    output logic [ID_W-1:0]    idx_c,
    output logic               any_c
);

    logic [ID_W-1:0]    ptr_q;
    logic [ID_W-1:0]    ptr_d;
    logic [ID_W-1:0]    slot_c;
    logic [NUM_REQ-1:0] elig_c;

    // Scan from the pointer, wrapping; the first eligible slot wins
    always_comb begin
        elig_c = req_i & ~mask_i;
        gnt_c  = '0;
        idx_c  = '0;
        any_c  = 1'b0;
        slot_c = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            slot_c = ID_W'(wrap_add(32'(ptr_q), i, NUM_REQ));
            if (!any_c && elig_c[slot_c]) begin
                any_c         = 1'b1;
                idx_c         = slot_c;
                gnt_c[slot_c] = 1'b1;
            end
        end
        ptr_d = advance_i ? ID_W'(wrap_add(32'(idx_c), 1, NUM_REQ)) : ptr_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/div_arbiter.sv
// Shares one iterative divider between NUM_REQ requesters. Grants round-robin,
// holds the owner's operands on the divider for the whole operation, drives the
// start/annul handshake and returns the {rem,quot} result tagged with the owner.
// Ports: clk, rst (async active-low); per-slot req_i/signed_i/op1_i/op2_i/flush_i;
// gnt_o (one-hot pulse), busy_o; rsp_valid_o/rsp_id_o/rsp_result_o response;
// div_start_o/div_annul_o/div_signed_o/div_op1_o/div_op2_o to the divider and
// div_result_i/div_ready_i from it. All outputs are registered.
module div_arbiter
    import div_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ    = 2,
    parameter int unsigned ID_W       = 1,
    parameter int unsigned CANCEL_CYC = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_i,
    input  logic [NUM_REQ-1:0]        signed_i,
    input  logic [NUM_REQ*DATA_W-1:0] op1_i,
    input  logic [NUM_REQ*DATA_W-1:0] op2_i,
    input  logic [NUM_REQ-1:0]        flush_i,
    output logic [NUM_REQ-1:0]        gnt_o,
    output logic                      busy_o,
    output logic                      rsp_valid_o,
    output logic [ID_W-1:0]           rsp_id_o,
    output logic [RESULT_W-1:0]       rsp_result_o,
    output logic                      div_start_o,
    output logic                      div_annul_o,
    output logic                      div_signed_o,
    output logic [DATA_W-1:0]         div_op1_o,
    output logic [DATA_W-1:0]         div_op2_o,
    input  logic [RESULT_W-1:0]       div_result_i,
    input  logic                      div_ready_i
);

    localparam int unsigned CNT_W = (CANCEL_CYC > 1) ? $clog2(CANCEL_CYC) : 1;

    div_ctrl_state_e     state_q, state_d;
    logic [ID_W-1:0]     owner_q, owner_d;
    logic [NUM_REQ-1:0]  gnt_q, gnt_d;
    div_op_t             op_q, op_d;
    logic                start_q, start_d;
    logic                annul_q, annul_d;
    logic                busy_q, busy_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [ID_W-1:0]     rsp_id_q, rsp_id_d;
    logic [RESULT_W-1:0] rsp_result_q, rsp_result_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;

    logic [NUM_REQ-1:0]  arb_gnt_c;
    logic [ID_W-1:0]     arb_idx_c;
    logic                arb_any_c;
    logic                advance_c;
    div_op_t             req_op [NUM_REQ];

    // Unpack per-slot operand payloads
    for (genvar k = 0; k < NUM_REQ; k++) begin : g_unpack
        assign req_op[k] = {signed_i[k],
                            op1_i[DATA_W*k +: DATA_W],
                            op2_i[DATA_W*k +: DATA_W]};
    end

    // Flushed slots are masked out of arbitration for the cycle they flush
    div_arbiter_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_rr (
        .clk       (clk),
        .rst       (rst),
        .req_i     (req_i),
        .mask_i    (flush_i),
        .advance_i (advance_c),
        .gnt_c     (arb_gnt_c),
        .idx_c     (arb_idx_c),
        .any_c     (arb_any_c)
    );

    // Controller next-state and output logic
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        gnt_d        = '0;
        op_d         = op_q;
        start_d      = start_q;
        annul_d      = annul_q;
        rsp_valid_d  = 1'b0;
        rsp_id_d     = rsp_id_q;
        rsp_result_d = rsp_result_q;
        cnt_d        = cnt_q;
        advance_c    = 1'b0;

        case (state_q)
            DIV_CTRL_IDLE: begin
                start_d = DIV_STOP;
                annul_d = 1'b0;
                if (arb_any_c) begin
                    gnt_d     = arb_gnt_c;
                    op_d      = req_op[arb_idx_c];
                    start_d   = DIV_START;
                    owner_d   = arb_idx_c;
                    advance_c = 1'b1;
                    state_d   = DIV_CTRL_BUSY;
                end
            end
            DIV_CTRL_BUSY: begin
                // Owner flush wins over a simultaneous result
                if (flush_i[owner_q]) begin
                    start_d = DIV_STOP;
                    annul_d = 1'b1;
                    cnt_d   = '0;
                    state_d = DIV_CTRL_CANCEL;
                end else if (div_ready_i == DIV_RESULT_READY) begin
                    rsp_result_d = div_result_i;
                    rsp_id_d     = owner_q;
                    rsp_valid_d  = 1'b1;
                    start_d      = DIV_STOP;
                    state_d      = DIV_CTRL_DONE;
                end
            end
            DIV_CTRL_DONE: begin
                // Divider needs one cycle of start low to leave its end state
                state_d = DIV_CTRL_IDLE;
            end
            DIV_CTRL_CANCEL: begin
                if (cnt_q == CNT_W'(CANCEL_CYC - 1)) begin
                    annul_d = 1'b0;
                    state_d = DIV_CTRL_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = DIV_CTRL_IDLE;
            end
        endcase

        busy_d = (state_d != DIV_CTRL_IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= DIV_CTRL_IDLE;
            owner_q      <= '0;
            gnt_q        <= '0;
            op_q         <= '0;
            start_q      <= 1'b0;
            annul_q      <= 1'b0;
            busy_q       <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= '0;
            rsp_result_q <= '0;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            gnt_q        <= gnt_d;
            op_q         <= op_d;
            start_q      <= start_d;
            annul_q      <= annul_d;
            busy_q       <= busy_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_id_q     <= rsp_id_d;
            rsp_result_q <= rsp_result_d;
            cnt_q        <= cnt_d;
        end
    end

    assign gnt_o        = gnt_q;
    assign busy_o       = busy_q;
    assign rsp_valid_o  = rsp_valid_q;
    assign rsp_id_o     = rsp_id_q;
    assign rsp_result_o = rsp_result_q;
    assign div_start_o  = start_q;
    assign div_annul_o  = annul_q;
    assign div_signed_o = op_q.is_signed;
    assign div_op1_o    = op_q.op1;
    assign div_op2_o    = op_q.op2;

endmodule
